booth_multiplier_seq: RTL and testbench
=======================================

Name: booth_multiplier_seq

Overview:
Parametrised, iterative radix-4 Booth multiplier for the arithmetic unit. It handles WIDTH-bit operands in signed or unsigned mode, selected per operation. It retires one Booth digit per clock and returns the full 2*WIDTH-bit product. Valid/ready handshakes on both sides let the ALU sequencer issue operations and apply backpressure on results.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4.
NDIG, WIDTH/2+1, number of radix-4 digits processed (derived, not overridable).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operands present on a, b, signed_mode.
in_ready  output  1  block can accept an operation (high only in IDLE).
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands; 0 = unsigned.
out_valid  output  1  product is valid (high only in DONE).
out_ready  input  1  consumer accepts the product.
product  output  2*WIDTH  a*b in the selected mode; exact, no overflow possible.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE and any in-flight operation is discarded.
  - in_ready=1, out_valid=0, busy=0, product=0, internal counter=0.
  - Reset has priority over every other event.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: capture a, b, signed_mode; counter<=0; go to RUN.
  - Operand extension to WIDTH+2 bits: sign-extended when signed_mode=1, zero-extended when 0.
  - Multiplier is extended the same way, with an implicit bit b[-1]=0.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge consumes digit i=counter from the triplet {b[2i+1], b[2i], b[2i-1]} of the extended multiplier.
  - Digit encoding: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - The partial product is added at weight 4^i into an accumulator of at least 2*WIDTH+4 bits, arithmetic throughout.
  - counter increments by 1.
  - On the edge that processes digit NDIG-1: product <= accumulator[2*WIDTH-1:0]; go to DONE.
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge (WIDTH=8: 5 edges). It is fixed and independent of operand values.
- DONE:
  - out_valid=1; product is held stable while out_valid=1 and out_ready=0.
  - On out_ready=1 at an edge: go to IDLE with out_valid=0. product keeps its last value until the next DONE.
  - No new operation is accepted in the same edge as the result handoff; in_ready returns to 1 the following cycle.
- No combinational path exists from in_valid or out_ready to any output.
- Edge cases:
  - Signed most-negative operands (-2^(W-1) * -2^(W-1)) must produce +2^(2W-2) exactly.
  - Unsigned all-ones operands must produce (2^W-1)^2 exactly.
  - For WIDTH=8, NDIG=5. The top digit is always 0 in signed mode and recovers the unsigned top bits in unsigned mode.
- Reset asserted during RUN or DONE: IDLE on that edge; no out_valid pulse follows.

Test Plan:
- WIDTH=8, signed_mode=1, a=0x80 (-128), b=0x80 -> out_valid exactly 5 edges after accept, product=0x4000.
- WIDTH=8, signed_mode=0, a=0xFF, b=0xFF -> product=0xFE01. Same operands with signed_mode=1 (-1*-1) -> product=0x0001.
- WIDTH=8, signed_mode=1, a=0x7F, b=0x81 (127*-127) -> product=0xC0FF. Unsigned a=0x00, b=0xAB -> product=0x0000.
- Backpressure: complete an operation, hold out_ready=0 for 10 cycles while toggling in_valid/a/b -> product, out_valid=1 and in_ready=0 are stable throughout. Then out_ready=1 for one edge -> IDLE, in_ready=1 the next cycle.
- Reset mid-op: accept a=3, b=5, assert rst on the 2nd RUN edge -> in_ready=1, busy=0, product=0, and no out_valid ever follows. A subsequent a=6, b=7 -> product=0x002A.
- WIDTH=16: 2000 random operands with random signed_mode and random out_ready stalls -> every product matches the reference multiply; latency is 9 edges for every operation.

Source files
------------

// File: rtl/booth_multiplier_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit per clock, signed or
// unsigned operands selected per operation, valid/ready on both sides.
module booth_multiplier_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned NDIG = WIDTH / 2 + 1;
    localparam int unsigned AW   = 2 * WIDTH + 4;
    localparam int unsigned BW   = WIDTH + 3;
    localparam int unsigned CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [AW-1:0]      r_acc;
    logic [AW-1:0]      r_mcand;
    logic [BW-1:0]      r_mplr;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_last;
    logic               w_a_sign;
    logic               w_b_sign;
    logic [AW-1:0]      w_mcand_init;
    logic [BW-1:0]      w_mplr_init;
    logic [2:0]         w_trip;
    logic [AW-1:0]      w_pp;
    logic [AW-1:0]      w_acc_next;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(NDIG - 1));

    assign w_a_sign     = signed_mode & a[WIDTH-1];
    assign w_b_sign     = signed_mode & b[WIDTH-1];
    assign w_mcand_init = {{(AW - WIDTH){w_a_sign}}, a};
    // Multiplier carries the implicit b[-1]=0 in bit 0.
    assign w_mplr_init  = {{2{w_b_sign}}, b, 1'b0};

    // Multiplicand is pre-shifted by 2 per digit, so the triplet is always r_mplr[2:0].
    assign w_trip = r_mplr[2:0];

    always_comb begin
        w_pp = '0;
        case (w_trip)
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = {r_mcand[AW-2:0], 1'b0};
            3'b100:         w_pp = '0 - {r_mcand[AW-2:0], 1'b0};
            3'b101, 3'b110: w_pp = '0 - r_mcand;
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_next = r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplr    <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_mcand   <= w_mcand_init;
            r_mplr    <= w_mplr_init;
            r_cnt     <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_mcand <= {r_mcand[AW-3:0], 2'b00};
            r_mplr  <= {{2{r_mplr[BW-1]}}, r_mplr[BW-1:2]};
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= w_acc_next[2*WIDTH-1:0];
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and reference-model checks for booth_multiplier_seq at WIDTH=8 and WIDTH=16.
module tb_booth_multiplier_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sm8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [15:0] product8;
    logic        busy8;

    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        sm16 = 1'b0;
    logic        out_valid16;
    logic        out_ready16 = 1'b0;
    logic [31:0] product16;
    logic        busy16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .product     (product8),
        .busy        (busy8)
    );

    booth_multiplier_seq #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .a           (a16),
        .b           (b16),
        .signed_mode (sm16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .product     (product16),
        .busy        (busy16)
    );

    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic tsm,
                          output logic [15:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!in_ready8 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a8 = ta; b8 = tb; sm8 = tsm; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product8;
    endtask

    task automatic finish8();
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input logic tsm,
                           output logic [31:0] prod, output int lat);
        int guard;
        guard = 0;
        while (!in_ready16 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a16 = ta; b16 = tb; sm16 = tsm; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        prod = product16;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready8); end
        n_checks++;
        if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid8); end
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy8); end
        n_checks++;
        if (product8 !== 16'h0000) begin n_fail++; $display("FAIL reset_product got %h exp 0000", product8); end
        n_checks++;
        if (in_ready16 !== 1'b1 || product16 !== 32'h0) begin
            n_fail++; $display("FAIL reset16 got in_ready=%b product=%h exp 1/0", in_ready16, product16);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  va [8] = '{8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h03, 8'hFE, 8'h7F};
        logic [7:0]  vb [8] = '{8'h80, 8'hFF, 8'hFF, 8'h81, 8'hAB, 8'h05, 8'h03, 8'h80};
        logic        vs [8] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
        logic [15:0] ve [8] = '{16'h4000, 16'hFE01, 16'h0001, 16'hC0FF,
                                16'h0000, 16'h000F, 16'hFFFA, 16'h3F80};
        logic [15:0] prod;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            do_op8(va[i], vb[i], vs[i], prod, lat);
            n_checks++;
            if (prod !== ve[i]) begin
                n_fail++;
                $display("FAIL corner%0d_product a=%h b=%h s=%b got %h exp %h", i, va[i], vb[i], vs[i], prod, ve[i]);
            end
            n_checks++;
            if (lat !== 5) begin n_fail++; $display("FAIL corner%0d_latency got %0d exp 5", i, lat); end
            n_checks++;
            if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
                n_fail++; $display("FAIL corner%0d_done_flags got busy=%b in_ready=%b exp 1/0", i, busy8, in_ready8);
            end
            finish8();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] prod;
        int          lat;
        do_op8(8'h12, 8'h34, 1'b0, prod, lat);
        n_checks++;
        if (prod !== 16'h03A8) begin n_fail++; $display("FAIL bp_product got %h exp 03a8", prod); end
        for (int i = 0; i < 10; i++) begin
            in_valid8 = ~in_valid8;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            sm8 = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (product8 !== 16'h03A8 || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got product=%h out_valid=%b in_ready=%b exp 03a8/1/0",
                         i, product8, out_valid8, in_ready8);
            end
        end
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        in_valid8 = 1'b0;
        n_checks++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handoff got out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid8, in_ready8, busy8);
        end
        n_checks++;
        if (product8 !== 16'h03A8) begin n_fail++; $display("FAIL bp_product_kept got %h exp 03a8", product8); end
    endtask

    task automatic test_reset_midop();
        logic [15:0] prod;
        int          lat;
        logic        seen;
        a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0 || product8 !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_state got in_ready=%b busy=%b product=%h exp 1/0/0000", in_ready8, busy8, product8);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid got %b exp 0", seen); end
        do_op8(8'd6, 8'd7, 1'b0, prod, lat);
        n_checks++;
        if (prod !== 16'h002A) begin n_fail++; $display("FAIL midrst_next_product got %h exp 002a", prod); end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL midrst_next_latency got %0d exp 5", lat); end
        finish8();
    endtask

    task automatic test_random16();
        logic [15:0] ta, tb;
        logic        tsm;
        logic [31:0] prod, expv;
        longint      p;
        int          lat;
        for (int i = 0; i < 2000; i++) begin
            ta  = 16'($urandom);
            tb  = 16'($urandom);
            tsm = 1'($urandom);
            if (tsm) p = longint'($signed(ta)) * longint'($signed(tb));
            else     p = longint'(ta) * longint'(tb);
            expv = p[31:0];
            do_op16(ta, tb, tsm, prod, lat);
            n_checks++;
            if (prod !== expv) begin
                n_fail++;
                $display("FAIL rand16_%0d_product a=%h b=%h s=%b got %h exp %h", i, ta, tb, tsm, prod, expv);
            end
            n_checks++;
            if (lat !== 9) begin n_fail++; $display("FAIL rand16_%0d_latency got %0d exp 9", i, lat); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if (product16 !== expv || out_valid16 !== 1'b1) begin
                n_fail++;
                $display("FAIL rand16_%0d_stall got product=%h out_valid=%b exp %h/1", i, product16, out_valid16, expv);
            end
            out_ready16 = 1'b1;
            @(posedge clk); #1;
            out_ready16 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_midop();
        test_random16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
